// File: rtl/round_pkg.sv
// Shared encodings for the reaction-game round controller: state codes,
// sound codes, LFSR mode codes and a lowest-index priority encoder.
package round_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WAIT      = 4'd1,
        ST_DARK      = 4'd2,
        ST_PLAY      = 4'd3,
        ST_FAKE      = 4'd4,
        ST_SPEED     = 4'd5,
        ST_GLOAT     = 4'd6,
        ST_FOUL      = 4'd7,
        ST_MATCH_END = 4'd8,
        ST_SHOW      = 4'd9
    } state_t;

    localparam logic [1:0] SND_OFF   = 2'b00;
    localparam logic [1:0] SND_WIN   = 2'b01;
    localparam logic [1:0] SND_FOUL  = 2'b10;
    localparam logic [1:0] SND_MATCH = 2'b11;

    localparam logic [1:0] RM_STAY  = 2'b00;
    localparam logic [1:0] RM_PLAY  = 2'b01;
    localparam logic [1:0] RM_FAKE  = 2'b10;
    localparam logic [1:0] RM_SPEED = 2'b11;

    function automatic logic [1:0] prio_enc(input logic [3:0] v);
        prio_enc = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) prio_enc = 2'(i);
        end
    endfunction

endpackage

// File: rtl/round_ctrl_multi_tick_timer.sv
// Counts slow ticks within one state; expire fires on the tick that
// completes 'term' ticks since the last clear.
module tick_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       tick,
    input  logic [3:0] term,
    output logic       expire
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = tick && (cnt_q == term - 4'd1);

endmodule

// File: rtl/round_ctrl_multi.sv
// Round sequencer for the multi-player reaction game: phase FSM, press
// arbitration, speed-round counters and per-player match scores.
module round_ctrl_multi
    import round_pkg::*;
#(
    parameter int N_PLAYERS     = 2,
    parameter int WAIT_TICKS    = 2,
    parameter int FAKE_TICKS    = 4,
    parameter int GLOAT_TICKS   = 2,
    parameter int SPEED_PRESSES = 8,
    parameter int WINS_TO_MATCH = 3,
    parameter int SPEED_EN      = 1,
    localparam int SCORE_W      = $clog2(WINS_TO_MATCH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic                         start_btn,
    input  logic                         score_btn,
    input  logic [N_PLAYERS-1:0]         press,
    input  logic [1:0]                   rand_mode,
    output logic [3:0]                   state_code,
    output logic                         leds_on,
    output logic                         clear,
    output logic                         fake,
    output logic                         speed_round,
    output logic [1:0]                   sound_ctrl,
    output logic                         round_valid,
    output logic [1:0]                   round_winner,
    output logic [N_PLAYERS*SCORE_W-1:0] scores,
    output logic                         match_over,
    output logic [1:0]                   match_winner
);

    localparam logic [SCORE_W-1:0] SCORE_MAX  = SCORE_W'(WINS_TO_MATCH);
    localparam logic [4:0]         SPEED_GOAL = 5'(SPEED_PRESSES);

    state_t                             state_q, state_d;
    logic [N_PLAYERS-1:0][SCORE_W-1:0]  score_q, score_d;
    logic [N_PLAYERS-1:0][4:0]          spd_q, spd_d;
    logic                               sbtn_q;
    logic [3:0]                         term;
    logic                               expire, tmr_clr;
    logic [3:0]                         press4, done4, max4;
    logic                               do_win, do_foul;
    logic [1:0]                         who;

    logic       leds_on_q, leds_on_d, clear_q, clear_d, fake_q, fake_d;
    logic       speed_q, speed_d, valid_q, valid_d, mover_q, mover_d;
    logic [1:0] sound_q, sound_d, winner_q, winner_d, mwin_q, mwin_d;

    tick_timer u_tmr (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .tick   (tick),
        .term   (term),
        .expire (expire)
    );

    always_comb begin
        case (state_q)
            ST_WAIT:           term = 4'(WAIT_TICKS);
            ST_FAKE:           term = 4'(FAKE_TICKS);
            ST_GLOAT, ST_FOUL: term = 4'(GLOAT_TICKS);
            default:           term = 4'd15;
        endcase
    end

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        spd_d   = spd_q;
        do_win  = 1'b0;
        do_foul = 1'b0;
        who     = 2'd0;
        press4  = '0;
        press4[N_PLAYERS-1:0] = press;
        done4   = '0;
        max4    = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            max4[i] = (score_q[i] == SCORE_MAX);
        end

        case (state_q)
            ST_IDLE: begin
                if (start_btn)      state_d = ST_WAIT;
                else if (score_btn) state_d = ST_SHOW;
            end
            ST_SHOW: if (score_btn && !sbtn_q) state_d = ST_IDLE;
            ST_WAIT: if (expire) state_d = ST_DARK;
            ST_DARK: begin
                // A press is judged before any tick landing in the same cycle.
                if (|press4) begin
                    do_foul = 1'b1;
                end else if (tick) begin
                    case (rand_mode)
                        RM_PLAY:  state_d = ST_PLAY;
                        RM_FAKE:  state_d = ST_FAKE;
                        RM_SPEED: if (SPEED_EN != 0) state_d = ST_SPEED;
                        default:  state_d = ST_DARK;
                    endcase
                end
            end
            ST_PLAY: if (|press4) do_win = 1'b1;
            ST_FAKE: begin
                if (|press4)     do_foul = 1'b1;
                else if (expire) state_d = ST_DARK;
            end
            ST_SPEED: begin
                for (int i = 0; i < N_PLAYERS; i++) begin
                    spd_d[i] = spd_q[i] + 5'(press[i]);
                    done4[i] = (spd_d[i] == SPEED_GOAL);
                end
                if (|done4) do_win = 1'b1;
            end
            ST_GLOAT, ST_FOUL: begin
                if (expire) state_d = (|max4) ? ST_MATCH_END : ST_WAIT;
            end
            ST_MATCH_END: begin
                if (start_btn) begin
                    state_d = ST_IDLE;
                    score_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_win) begin
            state_d = ST_GLOAT;
            who     = prio_enc((state_q == ST_SPEED) ? done4 : press4);
        end
        if (do_foul) begin
            state_d = ST_FOUL;
            who     = prio_enc(press4);
        end
        // Scores saturate at both ends rather than wrapping.
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (2'(i) == who) begin
                if (do_win && score_q[i] != SCORE_MAX) score_d[i] = score_q[i] + 1'b1;
                if (do_foul && score_q[i] != '0)       score_d[i] = score_q[i] - 1'b1;
            end
        end
        if (state_d == ST_SPEED && state_q != ST_SPEED) spd_d = '0;
    end

    assign tmr_clr = (state_d != state_q);

    always_comb begin
        leds_on_d = (state_d != ST_DARK);
        clear_d   = (state_d == ST_IDLE) || (state_d == ST_SHOW);
        fake_d    = (state_d == ST_FAKE);
        speed_d   = (state_d == ST_SPEED);
        mover_d   = (state_d == ST_MATCH_END);
        valid_d   = do_win || do_foul;
        winner_d  = valid_d ? who : winner_q;
        mwin_d    = (mover_d && state_q != ST_MATCH_END) ? prio_enc(max4) : mwin_q;
        case (state_d)
            ST_GLOAT:     sound_d = SND_WIN;
            ST_FOUL:      sound_d = SND_FOUL;
            ST_MATCH_END: sound_d = SND_MATCH;
            default:      sound_d = SND_OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            score_q   <= '0;
            spd_q     <= '0;
            sbtn_q    <= 1'b0;
            leds_on_q <= 1'b1;
            clear_q   <= 1'b1;
            fake_q    <= 1'b0;
            speed_q   <= 1'b0;
            sound_q   <= SND_OFF;
            valid_q   <= 1'b0;
            winner_q  <= 2'd0;
            mover_q   <= 1'b0;
            mwin_q    <= 2'd0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            spd_q     <= spd_d;
            sbtn_q    <= score_btn;
            leds_on_q <= leds_on_d;
            clear_q   <= clear_d;
            fake_q    <= fake_d;
            speed_q   <= speed_d;
            sound_q   <= sound_d;
            valid_q   <= valid_d;
            winner_q  <= winner_d;
            mover_q   <= mover_d;
            mwin_q    <= mwin_d;
        end
    end

    assign state_code   = state_q;
    assign leds_on      = leds_on_q;
    assign clear        = clear_q;
    assign fake         = fake_q;
    assign speed_round  = speed_q;
    assign sound_ctrl   = sound_q;
    assign round_valid  = valid_q;
    assign round_winner = winner_q;
    assign scores       = score_q;
    assign match_over   = mover_q;
    assign match_winner = mwin_q;

endmodule
